// File: rtl/vixen_tc_fill_scheduler.sv
// Trace-cache fill scheduler: per-thread fill FIFOs, round-robin grant onto the single
// fill port, and a flush sequencer that drains a thread's queue and strobes the cache.
module vixen_tc_fill_scheduler #(
   parameter int FIFO_DEPTH        = 2,
   parameter int FLUSH_WAIT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [191:0] req_uops_t0,
   input  logic [191:0] req_uops_t1,
   input  logic [2:0]   req_uvalid_t0,
   input  logic [2:0]   req_uvalid_t1,
   input  logic [63:0]  req_pc_t0,
   input  logic [63:0]  req_pc_t1,
   output logic         tc_fill_enable,
   output logic [191:0] tc_uops_in,
   output logic [2:0]   tc_valid_in,
   output logic [63:0]  tc_fill_pc,
   output logic [1:0]   tc_fill_thread_id,
   input  logic         flush_req,
   input  logic [1:0]   flush_req_tid,
   output logic         tc_flush,
   output logic [1:0]   tc_flush_thread_id,
   output logic         flush_busy,
   output logic [31:0]  perf_grants,
   output logic [31:0]  perf_discards
);

   // state       | meaning
   // IDLE        | no flush in progress
   // FLUSH_ISSUE | one-cycle tc_flush strobe for flush_mask
   // FLUSH_WAIT  | quiet countdown; re-issues for any flush merged meanwhile
   typedef enum logic [1:0] {IDLE, FLUSH_ISSUE, FLUSH_WAIT} state_t;

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(FLUSH_WAIT_CYCLES + 1);
   localparam int EW = 64 + 3 + 192;

   logic [EW-1:0]        mem [2][FIFO_DEPTH];
   logic [1:0][AW-1:0]   rd_ptr, wr_ptr;
   logic [1:0][CW-1:0]   count;
   logic [1:0][EW-1:0]   entry_in, head;
   logic [1:0]           full, empty, blocked, flush_hit, push, grant, elig, uvalid_any;
   logic                 last_grant;
   logic [31:0]          discard_now;

   state_t               state_q, state_d;
   logic [TW-1:0]        wait_cnt;
   logic [1:0]           flush_mask, pending, pend_eff;

   assign entry_in[0] = {req_pc_t0, req_uvalid_t0, req_uops_t0};
   assign entry_in[1] = {req_pc_t1, req_uvalid_t1, req_uops_t1};
   assign uvalid_any  = {|req_uvalid_t1, |req_uvalid_t0};

   always_comb begin
      for (int t = 0; t < 2; t++) begin
         full[t]  = (count[t] == CW'(FIFO_DEPTH));
         empty[t] = (count[t] == '0);
         head[t]  = mem[t][rd_ptr[t]];
      end
   end

   // A flush landing this cycle drops the thread's queue, so it must neither pop nor push.
   assign flush_hit = flush_req ? flush_req_tid : 2'b00;
   assign req_ready = ~full & ~blocked;
   assign push      = req_valid & req_ready & uvalid_any & ~flush_hit;
   assign elig      = ~empty & ~blocked & ~flush_hit;

   always_comb begin
      case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign discard_now = (flush_hit[0] ? 32'(count[0]) : 32'd0)
                      + (flush_hit[1] ? 32'(count[1]) : 32'd0);

   always_ff @(posedge clk) begin
      for (int t = 0; t < 2; t++) begin
         if (push[t]) mem[t][wr_ptr[t]] <= entry_in[t];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         last_grant <= 1'b1;
      end else begin
         for (int t = 0; t < 2; t++) begin
            if (flush_hit[t]) begin
               rd_ptr[t] <= '0;
               wr_ptr[t] <= '0;
               count[t]  <= '0;
            end else begin
               if (push[t])  wr_ptr[t] <= wr_ptr[t] + AW'(1);
               if (grant[t]) rd_ptr[t] <= rd_ptr[t] + AW'(1);
               count[t] <= count[t] + CW'(push[t]) - CW'(grant[t]);
            end
         end
         if (grant != 2'b00) last_grant <= grant[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tc_fill_enable    <= 1'b0;
         tc_uops_in        <= '0;
         tc_valid_in       <= '0;
         tc_fill_pc        <= '0;
         tc_fill_thread_id <= '0;
         perf_grants       <= '0;
         perf_discards     <= '0;
      end else begin
         tc_fill_enable <= |grant;
         if (grant[0]) begin
            {tc_fill_pc, tc_valid_in, tc_uops_in} <= head[0];
            tc_fill_thread_id                     <= 2'b01;
         end else if (grant[1]) begin
            {tc_fill_pc, tc_valid_in, tc_uops_in} <= head[1];
            tc_fill_thread_id                     <= 2'b10;
         end
         perf_grants   <= perf_grants + 32'(|grant);
         perf_discards <= perf_discards + discard_now;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Flushes arriving mid-sequence accumulate here and are re-issued after the wait.
   assign pend_eff = pending | ((state_q != IDLE) ? flush_hit : 2'b00);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (flush_hit != 2'b00) state_d = FLUSH_ISSUE;
         FLUSH_ISSUE: state_d = FLUSH_WAIT;
         FLUSH_WAIT:  if (wait_cnt == '0) state_d = (pend_eff != 2'b00) ? FLUSH_ISSUE : IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt   <= '0;
         flush_mask <= '0;
         pending    <= '0;
         blocked    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_hit != 2'b00) begin
                  flush_mask <= flush_hit;
                  blocked    <= flush_hit;
               end
            end
            FLUSH_ISSUE: begin
               wait_cnt <= TW'(FLUSH_WAIT_CYCLES);
               pending  <= pend_eff;
               blocked  <= blocked | flush_hit;
            end
            FLUSH_WAIT: begin
               if (wait_cnt == '0) begin
                  pending <= '0;
                  if (pend_eff != 2'b00) begin
                     flush_mask <= pend_eff;
                     blocked    <= pend_eff;
                  end else begin
                     blocked <= '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt - TW'(1);
                  pending  <= pend_eff;
                  blocked  <= blocked | flush_hit;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      flush_busy         = (state_q != IDLE);
      tc_flush           = (state_q == FLUSH_ISSUE);
      tc_flush_thread_id = (state_q == FLUSH_ISSUE) ? flush_mask : 2'b00;
   end

endmodule

// File: tb/tb_vixen_tc_fill_scheduler.sv
// Directed bench for vixen_tc_fill_scheduler: a cycle table for fills/arbitration plus
// hand sequences for backpressure, flush, merged flush and reset during a flush.
module tb_vixen_tc_fill_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid, req_ready;
   logic [191:0] req_uops_t0, req_uops_t1;
   logic [2:0]   req_uvalid_t0, req_uvalid_t1;
   logic [63:0]  req_pc_t0, req_pc_t1;
   logic         tc_fill_enable;
   logic [191:0] tc_uops_in;
   logic [2:0]   tc_valid_in;
   logic [63:0]  tc_fill_pc;
   logic [1:0]   tc_fill_thread_id;
   logic         flush_req;
   logic [1:0]   flush_req_tid;
   logic         tc_flush;
   logic [1:0]   tc_flush_thread_id;
   logic         flush_busy;
   logic [31:0]  perf_grants, perf_discards;

   int errors = 0;
   int checks = 0;

   vixen_tc_fill_scheduler #(.FIFO_DEPTH(2), .FLUSH_WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_uops_t0(req_uops_t0), .req_uops_t1(req_uops_t1),
      .req_uvalid_t0(req_uvalid_t0), .req_uvalid_t1(req_uvalid_t1),
      .req_pc_t0(req_pc_t0), .req_pc_t1(req_pc_t1),
      .tc_fill_enable(tc_fill_enable), .tc_uops_in(tc_uops_in), .tc_valid_in(tc_valid_in),
      .tc_fill_pc(tc_fill_pc), .tc_fill_thread_id(tc_fill_thread_id),
      .flush_req(flush_req), .flush_req_tid(flush_req_tid),
      .tc_flush(tc_flush), .tc_flush_thread_id(tc_flush_thread_id),
      .flush_busy(flush_busy), .perf_grants(perf_grants), .perf_discards(perf_discards)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [1:0]  v;
      logic [2:0]  uv0, uv1;
      logic [63:0] pc0, pc1;
      logic        fl;
      logic [1:0]  tid;
      logic [1:0]  e_rdy;
      logic        e_fen;
      logic [63:0] e_pc;
      logic [1:0]  e_tid;
      logic [2:0]  e_uv;
      logic        e_busy;
      logic [31:0] e_gr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [2:0] uv0,
                               input logic [2:0] uv1, input logic [63:0] pc0, input logic [63:0] pc1,
                               input logic fl, input logic [1:0] tid, input logic [1:0] e_rdy,
                               input logic e_fen, input logic [63:0] e_pc, input logic [1:0] e_tid,
                               input logic [2:0] e_uv, input logic e_busy, input logic [31:0] e_gr);
      vec_t x;
      x.r = r; x.v = v; x.uv0 = uv0; x.uv1 = uv1; x.pc0 = pc0; x.pc1 = pc1; x.fl = fl;
      x.tid = tid; x.e_rdy = e_rdy; x.e_fen = e_fen; x.e_pc = e_pc; x.e_tid = e_tid;
      x.e_uv = e_uv; x.e_busy = e_busy; x.e_gr = e_gr;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [1:0] v, input logic [2:0] u0, input logic [2:0] u1,
                        input logic [63:0] p0, input logic [63:0] p1, input logic f, input logic [1:0] ft);
      rst = r; req_valid = v; req_uvalid_t0 = u0; req_uvalid_t1 = u1;
      req_pc_t0 = p0; req_pc_t1 = p1; req_uops_t0 = {p0, p0, p0}; req_uops_t1 = {p1, p1, p1};
      flush_req = f; flush_req_tid = ft;
      tick;
   endtask

   task automatic idle;
      drive(1'b0, 2'b00, 3'b111, 3'b111, 64'h0, 64'h0, 1'b0, 2'b00);
   endtask

   task automatic do_reset;
      drive(1'b1, 2'b00, 3'b111, 3'b111, 64'h0, 64'h0, 1'b0, 2'b00);
   endtask

   logic [63:0] bp_exp0 [4];
   logic [63:0] bp_exp1 [3];

   initial begin
      int got0, got1, sent0, sent1, pulses;
      logic stall_seen;
      logic [1:0] acc;

      // contention from reset: t0 = 0x100.., t1 = 0x200.. with uvalid 011
      tbl.push_back(mk(0, 2'b11, 3'b111, 3'b011, 64'h100, 64'h200, 0, 2'b00, 2'b11, 0, 64'h0,   2'b00, 3'b000, 0, 0));
      tbl.push_back(mk(0, 2'b11, 3'b111, 3'b011, 64'h104, 64'h204, 0, 2'b00, 2'b01, 1, 64'h100, 2'b01, 3'b111, 0, 1));
      tbl.push_back(mk(0, 2'b11, 3'b111, 3'b011, 64'h108, 64'h208, 0, 2'b00, 2'b10, 1, 64'h200, 2'b10, 3'b011, 0, 2));
      tbl.push_back(mk(0, 2'b11, 3'b111, 3'b011, 64'h10C, 64'h208, 0, 2'b00, 2'b01, 1, 64'h104, 2'b01, 3'b111, 0, 3));
      tbl.push_back(mk(0, 2'b11, 3'b111, 3'b011, 64'h10C, 64'h20C, 0, 2'b00, 2'b10, 1, 64'h204, 2'b10, 3'b011, 0, 4));
      tbl.push_back(mk(0, 2'b10, 3'b111, 3'b011, 64'h0,   64'h20C, 0, 2'b00, 2'b01, 1, 64'h108, 2'b01, 3'b111, 0, 5));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b011, 64'h0,   64'h0,   0, 2'b00, 2'b11, 1, 64'h208, 2'b10, 3'b011, 0, 6));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b011, 64'h0,   64'h0,   0, 2'b00, 2'b11, 1, 64'h10C, 2'b01, 3'b111, 0, 7));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b011, 64'h0,   64'h0,   0, 2'b00, 2'b11, 1, 64'h20C, 2'b10, 3'b011, 0, 8));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b011, 64'h0,   64'h0,   0, 2'b00, 2'b11, 0, 64'h0,   2'b00, 3'b000, 0, 8));
      // reset, single fill, uvalid=000 request, mask-00 flush, partial-uvalid fill
      tbl.push_back(mk(1, 2'b00, 3'b111, 3'b111, 64'h0,    64'h0, 0, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 0));
      tbl.push_back(mk(0, 2'b01, 3'b111, 3'b111, 64'h1000, 64'h0, 0, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 0));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b111, 64'h0,    64'h0, 0, 2'b00, 2'b11, 1, 64'h1000, 2'b01, 3'b111, 0, 1));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b111, 64'h0,    64'h0, 0, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 1));
      tbl.push_back(mk(0, 2'b01, 3'b000, 3'b111, 64'h2000, 64'h0, 0, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 1));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b111, 64'h0,    64'h0, 0, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 1));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b111, 64'h0,    64'h0, 1, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 1));
      tbl.push_back(mk(0, 2'b01, 3'b101, 3'b111, 64'h3000, 64'h0, 0, 2'b00, 2'b11, 0, 64'h0,    2'b00, 3'b000, 0, 1));
      tbl.push_back(mk(0, 2'b00, 3'b111, 3'b111, 64'h0,    64'h0, 0, 2'b00, 2'b11, 1, 64'h3000, 2'b01, 3'b101, 0, 2));

      do_reset;
      do_reset;
      chk("rst_ready", req_ready, 2'b11);
      chk("rst_fen", tc_fill_enable, 0);
      chk("rst_fill_pc", tc_fill_pc, 0);
      chk("rst_fill_tid", tc_fill_thread_id, 0);
      chk("rst_flush", tc_flush, 0);
      chk("rst_flush_tid", tc_flush_thread_id, 0);
      chk("rst_busy", flush_busy, 0);
      chk("rst_grants", perf_grants, 0);
      chk("rst_discards", perf_discards, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].uv0, tbl[i].uv1, tbl[i].pc0, tbl[i].pc1, tbl[i].fl, tbl[i].tid);
         chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_rdy);
         chk($sformatf("v%0d_fen", i), tc_fill_enable, tbl[i].e_fen);
         chk($sformatf("v%0d_busy", i), flush_busy, tbl[i].e_busy);
         chk($sformatf("v%0d_flush", i), tc_flush, 0);
         chk($sformatf("v%0d_grants", i), perf_grants, tbl[i].e_gr);
         if (tbl[i].e_fen) begin
            chk($sformatf("v%0d_pc", i), tc_fill_pc, tbl[i].e_pc);
            chk($sformatf("v%0d_tid", i), tc_fill_thread_id, tbl[i].e_tid);
            chk($sformatf("v%0d_uv", i), tc_valid_in, tbl[i].e_uv);
            chk($sformatf("v%0d_uops", i), tc_uops_in == {tbl[i].e_pc, tbl[i].e_pc, tbl[i].e_pc}, 1);
         end
      end

      // backpressure: both threads held valid until accepted; fills must arrive in order
      bp_exp0 = '{64'h700, 64'h704, 64'h708, 64'h70C};
      bp_exp1 = '{64'h300, 64'h304, 64'h308};
      do_reset;
      got0 = 0; got1 = 0; sent0 = 0; sent1 = 0; stall_seen = 1'b0;
      for (int cyc = 0; cyc < 40 && (got0 < 4 || got1 < 3); cyc++) begin
         rst = 1'b0; flush_req = 1'b0; flush_req_tid = 2'b00;
         req_uvalid_t0 = 3'b111; req_uvalid_t1 = 3'b111;
         req_valid = {sent1 < 3, sent0 < 4};
         req_pc_t0 = (sent0 < 4) ? bp_exp0[sent0] : 64'h0;
         req_pc_t1 = (sent1 < 3) ? bp_exp1[sent1] : 64'h0;
         req_uops_t0 = {req_pc_t0, req_pc_t0, req_pc_t0};
         req_uops_t1 = {req_pc_t1, req_pc_t1, req_pc_t1};
         acc = req_valid & req_ready;
         if (req_valid[1] && !req_ready[1]) stall_seen = 1'b1;
         tick;
         if (acc[0]) sent0++;
         if (acc[1]) sent1++;
         if (tc_fill_enable) begin
            if (tc_fill_thread_id == 2'b01) begin
               if (got0 < 4) chk($sformatf("bp_t0_pc%0d", got0), tc_fill_pc, bp_exp0[got0]);
               got0++;
            end else if (tc_fill_thread_id == 2'b10) begin
               if (got1 < 3) chk($sformatf("bp_t1_pc%0d", got1), tc_fill_pc, bp_exp1[got1]);
               got1++;
            end else begin
               chk("bp_tid_onehot", tc_fill_thread_id, 2'b01);
            end
         end
      end
      chk("bp_t0_count", got0, 4);
      chk("bp_t1_count", got1, 3);
      chk("bp_t1_stall_seen", stall_seen, 1);
      chk("bp_grants", perf_grants, 7);

      // single flush of t0 holding two entries while t1 keeps filling
      do_reset;
      drive(0, 2'b11, 3'b111, 3'b111, 64'h500, 64'h600, 0, 2'b00);
      drive(0, 2'b11, 3'b111, 3'b111, 64'h504, 64'h604, 0, 2'b00);
      drive(0, 2'b01, 3'b111, 3'b111, 64'h508, 64'h0,   0, 2'b00);
      chk("fl_pre_ready", req_ready, 2'b10);
      drive(0, 2'b10, 3'b111, 3'b111, 64'h0, 64'h608, 1, 2'b01);
      chk("fl_strobe", tc_flush, 1);
      chk("fl_strobe_tid", tc_flush_thread_id, 2'b01);
      chk("fl_discards", perf_discards, 2);
      chk("fl_busy0", flush_busy, 1);
      chk("fl_ready0", req_ready, 2'b10);
      chk("fl_fill0_tid", tc_fill_thread_id, 2'b10);
      chk("fl_fill0_pc", tc_fill_pc, 64'h604);
      drive(0, 2'b10, 3'b111, 3'b111, 64'h0, 64'h60C, 0, 2'b00);
      chk("fl_strobe_off", tc_flush, 0);
      chk("fl_busy1", flush_busy, 1);
      chk("fl_fill1_pc", tc_fill_pc, 64'h608);
      chk("fl_fill1_tid", tc_fill_thread_id, 2'b10);
      drive(0, 2'b10, 3'b111, 3'b111, 64'h0, 64'h610, 0, 2'b00);
      chk("fl_busy2", flush_busy, 1);
      chk("fl_fill2_pc", tc_fill_pc, 64'h60C);
      idle;
      chk("fl_busy3", flush_busy, 1);
      chk("fl_fill3_pc", tc_fill_pc, 64'h610);
      chk("fl_fill3_fen", tc_fill_enable, 1);
      idle;
      chk("fl_busy_end", flush_busy, 0);
      chk("fl_ready_end", req_ready, 2'b11);
      chk("fl_fen_end", tc_fill_enable, 0);
      chk("fl_grants", perf_grants, 6);

      // merged flush: 01 at F, 10 at F+2
      do_reset;
      drive(0, 2'b00, 3'b111, 3'b111, 64'h0, 64'h0, 1, 2'b01);
      chk("mf_strobe1", tc_flush, 1);
      chk("mf_strobe1_tid", tc_flush_thread_id, 2'b01);
      idle;
      chk("mf_gap0", tc_flush, 0);
      drive(0, 2'b00, 3'b111, 3'b111, 64'h0, 64'h0, 1, 2'b10);
      chk("mf_ready_a", req_ready, 2'b00);
      chk("mf_gap1", tc_flush, 0);
      idle;
      chk("mf_ready_b", req_ready, 2'b00);
      chk("mf_gap2", tc_flush, 0);
      idle;
      chk("mf_strobe2", tc_flush, 1);
      chk("mf_strobe2_tid", tc_flush_thread_id, 2'b10);
      for (int k = 0; k < 3; k++) begin
         idle;
         chk($sformatf("mf_wait%0d_flush", k), tc_flush, 0);
         chk($sformatf("mf_wait%0d_busy", k), flush_busy, 1);
      end
      idle;
      chk("mf_busy_end", flush_busy, 0);
      chk("mf_ready_end", req_ready, 2'b11);

      // reset during FLUSH_WAIT
      do_reset;
      drive(0, 2'b00, 3'b111, 3'b111, 64'h0, 64'h0, 1, 2'b10);
      idle;
      chk("rw_in_wait", flush_busy, 1);
      do_reset;
      chk("rw_busy", flush_busy, 0);
      chk("rw_flush", tc_flush, 0);
      chk("rw_flush_tid", tc_flush_thread_id, 0);
      chk("rw_ready", req_ready, 2'b11);
      chk("rw_fen", tc_fill_enable, 0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         idle;
         if (tc_flush || flush_busy) pulses++;
      end
      chk("rw_no_flush_after", pulses, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
